// File: rtl/ambiente_robo.sv
// ambiente_robo: 8x8 grid environment for a cleaning robot.
// Holds the robot position, heading, debris bitmap, move counter and sticky
// error flags, and drives the sensors combinationally from that state.
// Optional macro AMBIENTE_DEBRIS_TIMER_EN: debris is removed only after four
// consecutive qualifying collect cycles, instead of on the first one.
module ambiente_robo #(
    parameter logic [63:0] WALL_MAP   = 64'h0,
    parameter logic [63:0] DEBRIS_MAP = 64'h0,
    parameter logic [2:0]  START_X    = 3'd0,
    parameter logic [2:0]  START_Y    = 3'd0,
    parameter logic [1:0]  START_DIR  = 2'd0,
    parameter logic [2:0]  EXIT_X     = 3'd7,
    parameter logic [2:0]  EXIT_Y     = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       avancar,
    input  logic       girar,
    input  logic       recolher_entulho,
    output logic       head,
    output logic       left,
    output logic       under,
    output logic       barrier,
    output logic [2:0] pos_x,
    output logic [2:0] pos_y,
    output logic [1:0] heading,
    output logic       collision,
    output logic       illegal,
    output logic       done,
    output logic [7:0] moves
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Neighbour of (x,y) in direction dir: {out_of_grid, ny, nx}; ny,nx form the map index
    function automatic logic [6:0] neighbour(input logic [2:0] x, input logic [2:0] y,
                                             input logic [1:0] dir);
        logic       oob;
        logic [2:0] nx;
        logic [2:0] ny;
        oob = 1'b0;
        nx  = x;
        ny  = y;
        case (dir)
            2'd0: begin oob = (y == 3'd7); ny = y + 3'd1; end
            2'd1: begin oob = (x == 3'd7); nx = x + 3'd1; end
            2'd2: begin oob = (y == 3'd0); ny = y - 3'd1; end
            2'd3: begin oob = (x == 3'd0); nx = x - 3'd1; end
            default: oob = 1'b1;
        endcase
        return {oob, ny, nx};
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_pos_x, r_pos_y, w_pos_x_next, w_pos_y_next;
    logic [1:0]  r_heading, w_heading_next;
    logic [63:0] r_debris, w_debris_next;
    logic [7:0]  r_moves, w_moves_next;
    logic        r_collision, w_collision_next;
    logic        r_illegal, w_illegal_next;
    logic [6:0]  w_front, w_left;
    logic        w_front_deb, w_front_blocked;
    logic [1:0]  w_cmd_cnt;
`ifdef AMBIENTE_DEBRIS_TIMER_EN
    logic [1:0]  r_hold, w_hold_next;
`endif

    // Sensors: decode front/left neighbours from registered state only
    always_comb begin
        w_front         = neighbour(r_pos_x, r_pos_y, r_heading);
        w_left          = neighbour(r_pos_x, r_pos_y, r_heading - 2'd1);
        w_front_deb     = ~w_front[6] & r_debris[w_front[5:0]];
        w_front_blocked = w_front[6] | WALL_MAP[w_front[5:0]] | w_front_deb;
        head            = w_front_blocked;
        barrier         = w_front_deb;
        left            = w_left[6] | WALL_MAP[w_left[5:0]];
        under           = (r_pos_x == EXIT_X) && (r_pos_y == EXIT_Y);
    end

    // Next-state logic: command decode, movement, debris removal, FSM transition
    always_comb begin
        w_state_next     = r_state;
        w_pos_x_next     = r_pos_x;
        w_pos_y_next     = r_pos_y;
        w_heading_next   = r_heading;
        w_debris_next    = r_debris;
        w_moves_next     = r_moves;
        w_collision_next = r_collision;
        w_illegal_next   = r_illegal;
`ifdef AMBIENTE_DEBRIS_TIMER_EN
        w_hold_next      = 2'd0;
`endif
        w_cmd_cnt = {1'b0, avancar} + {1'b0, girar} + {1'b0, recolher_entulho};
        if (r_state == ST_RUN) begin
            if (w_cmd_cnt >= 2'd2) begin
                w_illegal_next = 1'b1;
            end else if (avancar) begin
                if (w_front_blocked) begin
                    w_collision_next = 1'b1;
                end else begin
                    w_pos_x_next = w_front[2:0];
                    w_pos_y_next = w_front[5:3];
                    w_moves_next = (r_moves == 8'hFF) ? r_moves : r_moves + 8'd1;
                end
            end else if (girar) begin
                w_heading_next = r_heading + 2'd1;
            end else if (recolher_entulho && w_front_deb) begin
`ifdef AMBIENTE_DEBRIS_TIMER_EN
                if (r_hold == 2'd3) begin
                    w_debris_next[w_front[5:0]] = 1'b0;
                    w_hold_next                 = 2'd0;
                end else begin
                    w_hold_next = r_hold + 2'd1;
                end
`else
                w_debris_next[w_front[5:0]] = 1'b0;
`endif
            end else begin
                w_debris_next = r_debris;
            end
            // Enter DONE on the edge that leaves the robot on the exit cell
            if ((w_pos_x_next == EXIT_X) && (w_pos_y_next == EXIT_Y)) begin
                w_state_next = ST_DONE;
            end else begin
                w_state_next = ST_RUN;
            end
        end else begin
            w_state_next = ST_DONE;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_pos_x     <= START_X;
            r_pos_y     <= START_Y;
            r_heading   <= START_DIR;
            r_debris    <= DEBRIS_MAP;
            r_moves     <= 8'd0;
            r_collision <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pos_x     <= w_pos_x_next;
            r_pos_y     <= w_pos_y_next;
            r_heading   <= w_heading_next;
            r_debris    <= w_debris_next;
            r_moves     <= w_moves_next;
            r_collision <= w_collision_next;
            r_illegal   <= w_illegal_next;
        end
    end

`ifdef AMBIENTE_DEBRIS_TIMER_EN
    // Debris hold counter: counts consecutive qualifying collect cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold <= 2'd0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`endif

    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign heading   = r_heading;
    assign collision = r_collision;
    assign illegal   = r_illegal;
    assign moves     = r_moves;
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_ambiente_robo.sv
// Self-checking bench for ambiente_robo: directed scenarios plus randomized
// command streams compared against a grid-level reference model.
module tb_ambiente_robo;

    localparam logic [63:0] P_WALL   = 64'h0000_0008_0004_4000; // (6,1) (2,2) (3,4)
    localparam logic [63:0] P_DEBRIS = 64'h0002_0010_0000_0100; // (0,1) (4,4) (1,6)
    localparam int EX = 5;
    localparam int EY = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       avancar = 1'b0, girar = 1'b0, recolher_entulho = 1'b0;
    logic       head, left, under, barrier, collision, illegal, done;
    logic [2:0] pos_x, pos_y;
    logic [1:0] heading;
    logic [7:0] moves;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [63:0] wall_v = P_WALL;
    logic [63:0] m_deb;
    int  m_x, m_y, m_h, m_moves, m_hold;
    bit  m_col, m_ill, m_done;
    int  DX[4] = '{0, 1, 0, -1};
    int  DY[4] = '{1, 0, -1, 0};

    ambiente_robo #(
        .WALL_MAP(P_WALL), .DEBRIS_MAP(P_DEBRIS),
        .START_X(3'd0), .START_Y(3'd0), .START_DIR(2'd0),
        .EXIT_X(3'd5), .EXIT_Y(3'd5)
    ) dut (
        .clock(clock), .reset(reset),
        .avancar(avancar), .girar(girar), .recolher_entulho(recolher_entulho),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .collision(collision), .illegal(illegal), .done(done), .moves(moves)
    );

    always #5 clock = ~clock;

    function automatic bit m_is_wall(int x, int y);
        if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b1;
        return wall_v[y*8+x];
    endfunction

    function automatic bit m_has_deb(int x, int y);
        if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b0;
        return m_deb[y*8+x];
    endfunction

    task automatic model_reset();
        m_deb = P_DEBRIS; m_x = 0; m_y = 0; m_h = 0; m_moves = 0; m_hold = 0;
        m_col = 0; m_ill = 0; m_done = 0;
    endtask

    task automatic model_step(input bit a, input bit g, input bit r);
        int n, fx, fy;
        bit blocked, deb;
        n  = int'(a) + int'(g) + int'(r);
        fx = m_x + DX[m_h];
        fy = m_y + DY[m_h];
        deb = m_has_deb(fx, fy);
        blocked = m_is_wall(fx, fy) || deb;
        if (m_done) return;
        if (n >= 2) begin
            m_ill = 1; m_hold = 0;
        end else if (a) begin
            m_hold = 0;
            if (blocked) m_col = 1;
            else begin
                m_x = fx; m_y = fy;
                if (m_moves < 255) m_moves++;
            end
        end else if (g) begin
            m_hold = 0; m_h = (m_h + 1) % 4;
        end else if (r && deb) begin
`ifdef AMBIENTE_DEBRIS_TIMER_EN
            if (m_hold == 3) begin m_deb[fy*8+fx] = 1'b0; m_hold = 0; end
            else m_hold++;
`else
            m_deb[fy*8+fx] = 1'b0;
`endif
        end else begin
            m_hold = 0;
        end
        if (m_x == EX && m_y == EY) m_done = 1;
    endtask

    // one clock: drive at negedge, model follows the edge, outputs settle by #1
    task automatic cyc(input bit a, input bit g, input bit r);
        avancar = a; girar = g; recolher_entulho = r;
        @(posedge clock);
        model_step(a, g, r);
        #1;
        @(negedge clock);
        avancar = 0; girar = 0; recolher_entulho = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 1, 0);                      // heading -> E so reset has something to undo
        #2 reset = 1'b0;
        #1;
        checks++;
        if (heading !== 2'd0 || pos_x !== 3'd0 || pos_y !== 3'd0)
            begin failures++; $display("FAIL reset_async heading=%0d pos=(%0d,%0d) expected 0,(0,0)", heading, pos_x, pos_y); end
        model_reset();
        @(negedge clock); reset = 1'b1;
        checks++;
        if ({head, left, under, barrier, collision, illegal, done, moves} !== {7'b1101000, 8'd0})
            begin failures++; $display("FAIL reset_state got=%b_%0d expected=1101000_0", {head, left, under, barrier, collision, illegal, done}, moves); end
    endtask

    task automatic test_advance();
        do_reset();
        cyc(0, 1, 0);
        repeat (3) cyc(1, 0, 0);
        checks++;
        if (pos_x !== 3'd3 || pos_y !== 3'd0 || moves !== 8'd3 || head !== 1'b0 || collision !== 1'b0)
            begin failures++; $display("FAIL advance pos=(%0d,%0d) moves=%0d head=%b col=%b expected (3,0) 3 0 0", pos_x, pos_y, moves, head, collision); end
    endtask

    task automatic test_collision_turn();
        do_reset();
        repeat (3) cyc(0, 1, 0);
        checks++;
        if (heading !== 2'd3) begin failures++; $display("FAIL turn_wrap heading=%0d expected 3", heading); end
        cyc(1, 0, 0);
        checks++;
        if (pos_x !== 3'd0 || pos_y !== 3'd0 || collision !== 1'b1 || head !== 1'b1 || moves !== 8'd0)
            begin failures++; $display("FAIL collision pos=(%0d,%0d) col=%b head=%b moves=%0d expected (0,0) 1 1 0", pos_x, pos_y, collision, head, moves); end
        cyc(0, 1, 0);
        checks++;
        if (heading !== 2'd0) begin failures++; $display("FAIL turn_3_to_0 heading=%0d expected 0", heading); end
        repeat (3) cyc(0, 1, 0);
        checks++;
        if (heading !== 2'd3 || collision !== 1'b1)
            begin failures++; $display("FAIL turn_full heading=%0d col=%b expected 3 1", heading, collision); end
    endtask

    task automatic test_debris();
        do_reset();
        repeat (3) cyc(0, 0, 1);
        cyc(0, 0, 0);
        checks++;
`ifdef AMBIENTE_DEBRIS_TIMER_EN
        if (barrier !== 1'b1) begin failures++; $display("FAIL debris_partial barrier=%b expected 1", barrier); end
        repeat (3) cyc(0, 0, 1);
        checks++;
        if (barrier !== 1'b1) begin failures++; $display("FAIL debris_3of4 barrier=%b expected 1", barrier); end
        cyc(0, 0, 1);
`else
        if (barrier !== 1'b0) begin failures++; $display("FAIL debris_single barrier=%b expected 0", barrier); end
`endif
        checks++;
        if (barrier !== 1'b0 || head !== 1'b0 || left !== 1'b1)
            begin failures++; $display("FAIL debris_clear barrier=%b head=%b left=%b expected 0 0 1", barrier, head, left); end
        cyc(1, 0, 0);
        checks++;
        if (pos_y !== 3'd1 || moves !== 8'd1) begin failures++; $display("FAIL after_clear pos_y=%0d moves=%0d expected 1 1", pos_y, moves); end
    endtask

    task automatic test_illegal();
        do_reset();
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        checks++;
        if (illegal !== 1'b1 || heading !== 2'd1 || pos_x !== 3'd0 || pos_y !== 3'd0 || moves !== 8'd0)
            begin failures++; $display("FAIL illegal ill=%b heading=%0d pos=(%0d,%0d) moves=%0d expected 1 1 (0,0) 0", illegal, heading, pos_x, pos_y, moves); end
        cyc(1, 0, 0);
        checks++;
        if (illegal !== 1'b1 || pos_x !== 3'd1) begin failures++; $display("FAIL illegal_sticky ill=%b pos_x=%0d expected 1 1", illegal, pos_x); end
    endtask

    task automatic test_reset_mid_removal();
        do_reset();
        repeat (2) cyc(0, 0, 1);
        do_reset();
        checks++;
        if (barrier !== 1'b1) begin failures++; $display("FAIL reset_restores_debris barrier=%b expected 1", barrier); end
        repeat (2) cyc(0, 0, 1);
        checks++;
`ifdef AMBIENTE_DEBRIS_TIMER_EN
        if (barrier !== 1'b1) begin failures++; $display("FAIL hold_restart barrier=%b expected 1", barrier); end
`else
        if (barrier !== 1'b0) begin failures++; $display("FAIL removal_after_reset barrier=%b expected 0", barrier); end
`endif
    endtask

    task automatic test_done();
        do_reset();
        cyc(0, 1, 0);
        repeat (5) cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        repeat (4) cyc(1, 0, 0);
        checks++;
        if (done !== 1'b0 || pos_y !== 3'd4) begin failures++; $display("FAIL before_exit done=%b pos_y=%0d expected 0 4", done, pos_y); end
        cyc(1, 0, 0);
        checks++;
        if (done !== 1'b1 || under !== 1'b1 || pos_x !== 3'd5 || pos_y !== 3'd5 || moves !== 8'd10)
            begin failures++; $display("FAIL at_exit done=%b under=%b pos=(%0d,%0d) moves=%0d expected 1 1 (5,5) 10", done, under, pos_x, pos_y, moves); end
        cyc(1, 0, 0); cyc(0, 1, 0); cyc(1, 1, 0);
        checks++;
        if (done !== 1'b1 || pos_y !== 3'd5 || moves !== 8'd10 || heading !== 2'd0 || illegal !== 1'b0)
            begin failures++; $display("FAIL done_frozen pos_y=%0d moves=%0d heading=%0d ill=%b expected 5 10 0 0", pos_y, moves, heading, illegal); end
    endtask

    task automatic test_moves_saturate();
        do_reset();
        cyc(0, 1, 0);
        for (int k = 0; k < 33; k++) begin
            repeat (4) cyc(1, 0, 0);
            repeat (2) cyc(0, 1, 0);
            repeat (4) cyc(1, 0, 0);
            repeat (2) cyc(0, 1, 0);
        end
        checks++;
        if (moves !== 8'd255 || collision !== 1'b0 || pos_x !== 3'd0 || heading !== 2'd1)
            begin failures++; $display("FAIL moves_sat moves=%0d col=%b pos_x=%0d heading=%0d expected 255 0 0 1", moves, collision, pos_x, heading); end
    endtask

    task automatic test_random();
        logic [22:0] exp_v, got_v;
        int sel, fx, fy;
        bit a, g, r;
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                sel = $urandom_range(0, 9);
                a = (sel <= 3); g = (sel == 4 || sel == 5); r = (sel == 6 || sel == 7);
                if (sel == 9) {a, g, r} = 3'($urandom_range(0, 7));
                cyc(a, g, r);
                fx = m_x + DX[m_h]; fy = m_y + DY[m_h];
                exp_v = {m_is_wall(fx, fy) | m_has_deb(fx, fy),
                         m_is_wall(m_x + DX[(m_h+3)%4], m_y + DY[(m_h+3)%4]),
                         1'(m_x == EX && m_y == EY), m_has_deb(fx, fy),
                         3'(m_x), 3'(m_y), 2'(m_h), m_col, m_ill, m_done, 8'(m_moves)};
                got_v = {head, left, under, barrier, pos_x, pos_y, heading, collision, illegal, done, moves};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL random ep=%0d cyc=%0d cmd=%b%b%b got=%h expected=%h", ep, c, a, g, r, got_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_collision_turn();
        test_debris();
        test_illegal();
        test_reset_mid_removal();
        test_done();
        test_moves_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ambiente_robo.md
AMBIENTE_ROBO -- requirements
Module: ambiente_robo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WALL_MAP, 64'h0, bit y*8+x = 1 marks cell (x,y) as wall.
- DEBRIS_MAP, 64'h0, bit y*8+x = 1 marks cell (x,y) as holding debris at reset.
- START_X / START_Y, 3'd0 / 3'd0, initial robot cell.
- START_DIR, 2'd0, initial heading (0=N, 1=E, 2=S, 3=W).
- EXIT_X / EXIT_Y, 3'd7 / 3'd7, exit cell.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- avancar / girar / recolher_entulho, in, 1 each, robot commands.
- head / left / under / barrier, out, 1 each, sensor outputs to robot.
- pos_x / pos_y, out, 3 each, current cell.
- heading, out, 2, current direction.
- collision, out, 1, sticky: blocked advance attempted.
- illegal, out, 1, sticky: more than one command high in a cycle.
- done, out, 1, robot has reached the exit.
- moves, out, 8, count of successful advances, saturating at 255.

Function
REQ-003 Front cell SHALL be the neighbour in the heading direction (N: y+1, E: x+1, S: y-1, W: x-1); left cell SHALL be the neighbour at heading-1 mod 4; any neighbour outside 0..7 SHALL count as wall.
REQ-004 head SHALL be 1 iff the front cell is wall or debris; left SHALL be 1 iff the left cell is wall; barrier SHALL be 1 iff the front cell holds debris; under SHALL be 1 iff the current cell equals (EXIT_X, EXIT_Y).
REQ-005 Sensor outputs SHALL be combinational from registered state, with zero-cycle latency after any state update.
REQ-006 FSM states SHALL be RUN and DONE; reset SHALL enter RUN; RUN SHALL go to DONE on the edge after which position equals the exit; DONE SHALL be left only by reset.
REQ-007 In DONE, all commands SHALL be ignored and position, heading, debris, moves and the sticky flags SHALL hold.
REQ-008 In RUN, if two or more commands are high, illegal SHALL set and no other state SHALL change that cycle.
REQ-009 In RUN, avancar alone with head=0 SHALL move one cell forward and increment moves (saturating at 255); with head=1 it SHALL set collision and leave position unchanged.
REQ-010 In RUN, girar alone SHALL rotate clockwise: heading <= heading+1 mod 4, with 3 wrapping to 0.
REQ-011 In RUN, recolher_entulho alone with barrier=1 SHALL advance the debris removal (REQ-016); with barrier=0 it SHALL have no effect.
REQ-012 The debris hold counter SHALL clear in any cycle where recolher_entulho is not the sole active command or barrier=0.
REQ-013 done SHALL equal (state == DONE).

Reset
REQ-014 While reset=0, the following SHALL hold, asynchronously:
- pos = (START_X, START_Y), heading = START_DIR
- debris bitmap = DEBRIS_MAP, hold counter = 0
- moves = 0, collision = 0, illegal = 0, state = RUN
REQ-015 Reset asserted mid-removal or mid-run SHALL discard all progress; the first command after release SHALL be evaluated on the first rising edge.

Configuration
REQ-016 Macro AMBIENTE_DEBRIS_TIMER_EN SHALL select the debris removal mode.
- Defined: a 2-bit hold counter increments each qualifying cycle; the front debris bit clears on the 4th consecutive qualifying cycle; the counter then returns to 0.
- Undefined: the front debris bit clears on the first qualifying cycle; no counter is instantiated.

Verification
REQ-017 Reset with START=(0,0), START_DIR=N, empty maps; apply avancar 3 cycles -> pos=(0,3), moves=3, head=0, collision=0.
REQ-018 Start (0,0), heading W; apply avancar 1 cycle -> pos unchanged, collision=1, head=1; apply girar 4 cycles -> heading returns to 3.
REQ-019 DEBRIS_MAP bit 8 set, start (0,0) heading N; recolher_entulho for 3 cycles then drop -> barrier stays 1 (TIMER_EN); hold it 4 cycles -> barrier=0 and head=0 on the following cycle; without macro, 1 cycle suffices.
REQ-020 Apply avancar+girar together -> illegal=1, pos and heading unchanged.
REQ-021 EXIT=(0,1), start (0,0) heading N; avancar 1 cycle -> under=1, done=1; further avancar -> pos and moves frozen.
REQ-022 Assert reset after 2 of 4 removal cycles, release, apply 2 more cycles -> debris still present (counter restarted from 0).
